// File: rtl/wlif_bank.sv
// Multi-channel weighted leaky integrate-and-fire trace bank with shared decay prescaler.
// Latency: 1 cycle from i_event to o_do. No backpressure: events are sampled every edge.
// Optional exponential decay is enabled with WLIF_EXP_DECAY_EN (adds i_exp_mode, i_shift).
module wlif_bank #(
    parameter int P_CH      = 4,
    parameter int P_WIDTH   = 8,
    parameter int P_NBIT    = 8,
    parameter int P_PRESC_W = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [P_CH-1:0]                       i_event,
    input  logic [P_CH*P_WIDTH-1:0]               i_weight,
    input  logic                                  i_accum,
    input  logic [P_PRESC_W-1:0]                  i_presc,
`ifdef WLIF_EXP_DECAY_EN
    input  logic                                  i_exp_mode,
    input  logic [3:0]                            i_shift,
`endif
    output logic [P_CH-1:0]                       o_clr,
    output logic [P_CH*(P_WIDTH+P_NBIT)-1:0]      o_do,
    output logic                                  o_active
);

    localparam int TW = P_WIDTH + P_NBIT;

    typedef enum logic {
        S_CLR   = 1'b0,
        S_ARMED = 1'b1
    } clr_state_t;

    logic [P_PRESC_W-1:0] cnt_q, cnt_d;
    logic                 tick;
    logic [P_CH-1:0]      ch_active;

    // Comparing with >= lets a lowered period take effect immediately.
    always_comb begin
        tick  = (cnt_q >= i_presc);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k < P_CH; k++) begin : g_ch
            logic [P_WIDTH-1:0] w;
            logic [TW-1:0]      w_ext;
            logic [TW-1:0]      s_val;
            logic [TW:0]        sum;
            logic [TW-1:0]      lin_dec;
            logic [TW-1:0]      dec_val;
            logic [TW-1:0]      trace_q, trace_d;
            clr_state_t         state_q, state_d;
            logic               clr;

            assign w       = i_weight[k*P_WIDTH +: P_WIDTH];
            assign w_ext   = {{P_NBIT{1'b0}}, w};
            assign s_val   = {w, {P_NBIT{1'b0}}};
            assign sum     = {1'b0, trace_q} + {1'b0, s_val};
            assign lin_dec = (trace_q > w_ext) ? (trace_q - w_ext) : '0;

`ifdef WLIF_EXP_DECAY_EN
            logic [TW-1:0] exp_d;
            logic [TW-1:0] exp_dec;

            // Fall back to -1 once the shifted step vanishes so the trace always reaches zero.
            assign exp_d   = trace_q >> i_shift;
            assign exp_dec = (exp_d != '0)   ? (trace_q - exp_d) :
                             (trace_q != '0) ? (trace_q - 1'b1)  : '0;
            assign dec_val = i_exp_mode ? exp_dec : lin_dec;
`else
            assign dec_val = lin_dec;
`endif

            always_comb begin
                trace_d = trace_q;
                if (i_event[k]) begin
                    if (i_accum) begin
                        trace_d = sum[TW] ? '1 : sum[TW-1:0];
                    end else begin
                        trace_d = s_val;
                    end
                end else if (tick) begin
                    trace_d = dec_val;
                end
            end

            always_comb begin
                state_d = state_q;
                clr     = 1'b0;
                case (state_q)
                    S_CLR: begin
                        clr     = 1'b1;
                        state_d = S_ARMED;
                    end
                    S_ARMED: begin
                        if (i_event[k]) begin
                            state_d = S_CLR;
                        end
                    end
                    default: state_d = S_CLR;
                endcase
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    trace_q <= '0;
                    state_q <= S_CLR;
                end else begin
                    trace_q <= trace_d;
                    state_q <= state_d;
                end
            end

            assign o_clr[k]          = clr;
            assign o_do[k*TW +: TW]  = trace_q;
            assign ch_active[k]      = |trace_q;
        end
    endgenerate

    assign o_active = |ch_active;

endmodule

// File: tb/tb_wlif_bank.sv
// Directed bench for wlif_bank: table of per-cycle vectors plus hand sequences for long decay,
// prescaler retiming, reset and (when WLIF_EXP_DECAY_EN is defined) exponential decay.
module tb_wlif_bank;

    logic        i_clk;
    logic        i_rst_n;
    logic [3:0]  i_event;
    logic [31:0] i_weight;
    logic        i_accum;
    logic [3:0]  i_presc;
`ifdef WLIF_EXP_DECAY_EN
    logic        i_exp_mode;
    logic [3:0]  i_shift;
`endif
    logic [3:0]  o_clr;
    logic [63:0] o_do;
    logic        o_active;

    int n_vec;
    int n_err;

    wlif_bank #(.P_CH(4), .P_WIDTH(8), .P_NBIT(8), .P_PRESC_W(4)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_event   (i_event),
        .i_weight  (i_weight),
        .i_accum   (i_accum),
        .i_presc   (i_presc),
`ifdef WLIF_EXP_DECAY_EN
        .i_exp_mode(i_exp_mode),
        .i_shift   (i_shift),
`endif
        .o_clr     (o_clr),
        .o_do      (o_do),
        .o_active  (o_active)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  ev;
        logic [31:0] wt;
        logic        acc;
        logic [3:0]  presc;
        logic [63:0] exp_do;
        logic [3:0]  exp_clr;
        logic        exp_act;
    } vec_t;

    localparam int NTBL = 13;
    vec_t tbl [NTBL];

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] e_do,
                         input logic [3:0] e_clr, input logic e_act);
        n_vec++;
        if (o_do !== e_do || o_clr !== e_clr || o_active !== e_act) begin
            n_err++;
            $display("FAIL %s: got o_do=%h o_clr=%b o_active=%b, want o_do=%h o_clr=%b o_active=%b",
                     name, o_do, o_clr, o_active, e_do, e_clr, e_act);
        end
    endtask

    // Asynchronous reset from mid-operation, held across one edge, released just after an edge.
    task automatic do_reset(input string name);
        i_rst_n = 1'b0;
        #2;
        check(name, 64'h0, 4'hF, 1'b0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    logic [15:0] b_exp [10];

`ifdef WLIF_EXP_DECAY_EN
    function automatic logic [15:0] exp_model(input logic [15:0] t, input int sh);
        logic [15:0] d;
        d = t >> sh;
        if (d != 16'h0)      return t - d;
        else if (t != 16'h0) return t - 16'h1;
        else                 return 16'h0;
    endfunction
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        //              ev       weights        acc   presc  {T3,T2,T1,T0}             clr      act
        tbl[0]  = '{4'b0000, 32'h05C01003, 1'b0, 4'd0, 64'h0000_0000_0000_0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0001, 32'h05C01003, 1'b0, 4'd0, 64'h0000_0000_0000_0300, 4'b0001, 1'b1};
        tbl[2]  = '{4'b0000, 32'h05C01003, 1'b0, 4'd0, 64'h0000_0000_0000_02FD, 4'b0000, 1'b1};
        tbl[3]  = '{4'b0000, 32'h05C01003, 1'b0, 4'd0, 64'h0000_0000_0000_02FA, 4'b0000, 1'b1};
        tbl[4]  = '{4'b0100, 32'h05C01003, 1'b1, 4'd0, 64'h0000_C000_0000_02F7, 4'b0100, 1'b1};
        tbl[5]  = '{4'b0100, 32'h05C01003, 1'b1, 4'd0, 64'h0000_FFFF_0000_02F4, 4'b0000, 1'b1};
        tbl[6]  = '{4'b0000, 32'h05C01003, 1'b1, 4'd0, 64'h0000_FF3F_0000_02F1, 4'b0000, 1'b1};
        tbl[7]  = '{4'b1000, 32'h02C01003, 1'b0, 4'd0, 64'h0200_FE7F_0000_02EE, 4'b1000, 1'b1};
        tbl[8]  = '{4'b1000, 32'h05C01003, 1'b0, 4'd0, 64'h0500_FDBF_0000_02EB, 4'b0000, 1'b1};
        tbl[9]  = '{4'b1111, 32'h05C01003, 1'b0, 4'd0, 64'h0500_C000_1000_0300, 4'b1111, 1'b1};
        tbl[10] = '{4'b0000, 32'h05C01003, 1'b0, 4'd0, 64'h04FB_BF40_0FF0_02FD, 4'b0000, 1'b1};
        tbl[11] = '{4'b0010, 32'h05C01003, 1'b1, 4'd0, 64'h04F6_BE80_1FF0_02FA, 4'b0010, 1'b1};
        tbl[12] = '{4'b0000, 32'h05C01000, 1'b0, 4'd0, 64'h04F1_BDC0_1FE0_02FA, 4'b0000, 1'b1};

        b_exp = '{16'h1000, 16'h1000, 16'h1000, 16'h0FF0, 16'h0FF0,
                  16'h0FF0, 16'h0FF0, 16'h0FE0, 16'h0FE0, 16'h0FE0};

        i_rst_n  = 1'b0;
        i_event  = '0;
        i_weight = '0;
        i_accum  = 1'b0;
        i_presc  = '0;
`ifdef WLIF_EXP_DECAY_EN
        i_exp_mode = 1'b0;
        i_shift    = '0;
`endif
        #12;
        check("reset", 64'h0, 4'hF, 1'b0);
        i_rst_n = 1'b1;

        for (int i = 0; i < NTBL; i++) begin
            i_event  = tbl[i].ev;
            i_weight = tbl[i].wt;
            i_accum  = tbl[i].acc;
            i_presc  = tbl[i].presc;
            step();
            check($sformatf("tbl[%0d]", i), tbl[i].exp_do, tbl[i].exp_clr, tbl[i].exp_act);
        end

        // Full linear decay of ch0 from 0x0300 by 3 per cycle: zero exactly 256 cycles after load.
        i_event = '0;
        do_reset("reset_mid_op_a");
        i_weight = 32'h0000_0003;
        i_accum  = 1'b0;
        i_presc  = 4'd0;
        step();
        check("release_a", 64'h0, 4'h0, 1'b0);
        i_event = 4'b0001;
        step();
        check("load_a", 64'h0300, 4'b0001, 1'b1);
        i_event = '0;
        for (int k = 1; k <= 256; k++) begin
            logic [15:0] e;
            e = (k < 256) ? 16'(16'h0300 - 3 * k) : 16'h0;
            step();
            check($sformatf("decay_a[%0d]", k), {48'h0, e}, 4'b0000, (k < 256));
        end

        // Prescaled decay on ch1, then period lowered from 3 to 0 while the counter sits at 2.
        do_reset("reset_mid_op_b");
        i_weight = 32'h0000_1000;
        i_presc  = 4'd3;
        i_event  = 4'b0010;
        step();
        check("presc_b[1]", {32'h0, b_exp[0], 16'h0}, 4'b0000, 1'b1);
        i_event = '0;
        for (int k = 1; k < 10; k++) begin
            step();
            check($sformatf("presc_b[%0d]", k + 1), {32'h0, b_exp[k], 16'h0}, 4'b0000, 1'b1);
        end
        i_presc = 4'd0;
        step();
        check("presc_drop_b", {32'h0, 16'h0FD0, 16'h0}, 4'b0000, 1'b1);
        step();
        check("presc0_b[1]", {32'h0, 16'h0FC0, 16'h0}, 4'b0000, 1'b1);
        step();
        check("presc0_b[2]", {32'h0, 16'h0FB0, 16'h0}, 4'b0000, 1'b1);

`ifdef WLIF_EXP_DECAY_EN
        begin
            logic [15:0] t;
            do_reset("reset_mid_op_c");
            i_weight   = 32'h0000_0001;
            i_presc    = 4'd0;
            i_exp_mode = 1'b1;
            i_shift    = 4'd2;
            step();
            i_event = 4'b0001;
            step();
            check("exp_load", 64'h0100, 4'b0001, 1'b1);
            i_event = '0;
            step();
            check("exp_c0", 64'h00C0, 4'b0000, 1'b1);
            step();
            check("exp_90", 64'h0090, 4'b0000, 1'b1);
            t = 16'h0090;
            for (int k = 0; k < 64 && t != 16'h0; k++) begin
                t = exp_model(t, 2);
                step();
                check($sformatf("exp_tail[%0d]", k), {48'h0, t}, 4'b0000, (t != 16'h0));
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
